// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int ILEN_DEFAULT = 32;
    localparam int PC_STEP      = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc, inst} entries with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    parameter int  CW      = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipelined PC generator and icache requester feeding the ID queue
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN            = XLEN_DEFAULT,
    parameter int ILEN            = ILEN_DEFAULT,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] entry,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic            misalign_err
);

    localparam int CW = count_width(QUEUE_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            issue;
    logic            accept;
    logic            resp_live;
    logic            pop;
    entry_t          head;
    entry_t          push_data;

    // Every live in-flight request already owns a queue slot; stale ones do not.
    assign credit    = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop};
    assign req_valid = !reset && !halted && !redirect_valid
                       && (outstanding < CW'(MAX_OUTSTANDING))
                       && (credit < (CW+1)'(QUEUE_DEPTH));
    assign req_addr  = fetch_pc;
    assign issue     = req_valid && req_ready;
    assign resp_live = resp_valid && (outstanding != '0);
    assign accept    = resp_valid && !redirect_valid && (drop == '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign push_data = '{pc: resp_pc, inst: resp_inst};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= entry;
            resp_pc      <= entry;
            outstanding  <= '0;
            drop         <= '0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CW'(resp_live);
            drop        <= outstanding - CW'(resp_live);
            halted      <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
            outstanding <= outstanding + CW'(issue) - CW'(resp_live);
            if (resp_valid && drop != '0) begin
                drop <= drop - 1'b1;
            end
            if (accept) begin
                resp_pc <= resp_pc + XLEN'(PC_STEP);
                if (resp_inst == '0) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && resp_valid && outstanding == '0) begin
            $error("fetch_unit: resp_valid with no request outstanding");
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (QUEUE_DEPTH),
        .CW      (CW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the single-instruction PC state machine.
- Generates sequential PCs and issues pipelined requests to the icache over a valid/ready handshake, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions with their PCs in a QUEUE_DEPTH FIFO feeding the ID stage.
- Handles redirects (jumps/branches) by flushing the queue and discarding stale in-flight responses; stops fetching after a zero instruction (program terminator).

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum icache requests in flight; 1..QUEUE_DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- entry  in  XLEN  PC loaded at reset.
- req_valid  out  1  icache request valid.
- req_ready  in  1  icache accepts request.
- req_addr  out  XLEN  request address (fetch_pc).
- resp_valid  in  1  icache returns one instruction; always accepted, responses arrive in request order.
- resp_inst  in  ILEN  returned instruction.
- out_valid  out  1  queue head valid to ID.
- out_ready  in  1  ID consumes head.
- out_pc  out  XLEN  PC of head.
- out_inst  out  ILEN  instruction at head.
- redirect_valid  in  1  jump/branch taken; highest priority.
- redirect_pc  in  XLEN  target PC.
- halted  out  1  zero instruction enqueued; fetch stopped.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset, synchronous and active-high:
  - fetch_pc and resp_pc load entry.
  - Queue empties; outstanding and drop counters go to 0.
  - req_valid, out_valid, halted and misalign_err go to 0.
  - Reset mid-operation abandons all in-flight responses. The icache is reset on the same reset, so no drop accounting carries over.
- Issue:
  - req_valid = !halted && !redirect_valid && outstanding < MAX_OUTSTANDING && (count + outstanding - drop) < QUEUE_DEPTH.
  - The last term is the credit check: every live in-flight request owns a reserved slot, so the queue never overflows.
  - On req_valid && req_ready: fetch_pc += 4 (mod 2^XLEN, wraps silently) and outstanding increments.
  - req_addr is stable while req_valid && !req_ready.
- Response, on resp_valid:
  - outstanding decrements; simultaneous issue and response leaves it unchanged.
  - If drop > 0: drop decrements and the response is discarded.
  - Otherwise push {resp_pc, resp_inst} and resp_pc += 4.
  - resp_valid with outstanding == 0 is a protocol violation; flag it with $error.
- Latency: a response in cycle N makes out_valid visible in cycle N+1; the queue output is registered.
- Output:
  - out_valid = (count != 0); out_pc/out_inst come from the head entry.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop keeps count unchanged; the full case is allowed.
- Redirect, in the cycle redirect_valid is high:
  - Next state: fetch_pc and resp_pc load {redirect_pc[XLEN-1:2], 2'b00}.
  - The queue flushes (count 0); any pop in that cycle is ignored.
  - drop = outstanding - resp_valid; outstanding = outstanding - resp_valid. A response arriving in that cycle is discarded.
  - halted clears.
  - misalign_err sets if redirect_pc[1:0] != 0.
  - No request is issued in the redirect cycle. The first new request goes out in cycle +1.
  - Back-to-back redirects: each one recomputes drop from the current outstanding count; the last redirect wins.
- Halt:
  - Pushing an instruction equal to 0 sets halted next cycle and blocks further issue.
  - Responses already in flight still arrive and are enqueued.
  - The zero instruction is delivered normally so ID can end simulation.
  - Only reset or a redirect clears halted.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {logic [XLEN-1:0] pc; logic [ILEN-1:0] inst;}.
  - Localparam PC_STEP = 4.
  - Counter width via $clog2(QUEUE_DEPTH+1).
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush (flush has priority) and count.
  - Pointers wrap modulo QUEUE_DEPTH.
- fetch_unit holds the PC, outstanding/drop counters and the halt/error flags.

Test Plan:
- Sequential stream: reset with entry=0x1000, req_ready=1, icache returns one cycle after each request, out_ready=1 → out_pc is 0x1000, 0x1004, 0x1008… one per cycle after fill, in order with correct instructions.
- Backpressure: out_ready=0, instant icache → exactly 4 entries queued, req_valid drops, outstanding 0. Raise out_ready → four pops with no loss or duplication, then fetch resumes.
- Redirect with 2 in flight: redirect_pc=0x2000 while outstanding=2 and no response that cycle → next two responses discarded, next out_pc=0x2000, drop returns to 0.
- Redirect coincident with a response, plus a misaligned target: redirect_pc=0x3002 with outstanding=2 and resp_valid=1 → drop=1, first delivered out_pc=0x3000, misalign_err=1 and stays high.
- Halt: memory returns 0x00000013 at 0x1000 and 0x00000000 at 0x1004 → both delivered, halted=1, req_valid stays 0. A later redirect to 0x1000 clears halted and fetch restarts.
- Reset mid-stream: assert reset with 2 in flight and 3 queued → next cycle out_valid=0, req_valid=0, halted=0, fetch restarts at entry.
